// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: parity selection, TX/RX state
// encodings and the oversampling ratio.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, shared by TX and RX.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_gen: DIV must be at least 1");
  end

  assign wrap   = (cnt_q == CW'(DIV - 1));
  assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
  assign tick_o = wrap;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: 16x oversampled transmitter and receiver sharing one tick,
// with a one-word receive holding register, error flags and sticky overrun.
module uart_core
  import uart_pkg::*;
#(
  parameter int      DATA_WIDTH = 8,
  parameter int      CLK_FREQ   = 50000000,
  parameter int      BAUD_RATE  = 19200,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_active,
  output logic                  tx_done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int         DIV       = CLK_FREQ / (OVERSAMPLE * BAUD_RATE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic       PAR_INV   = (PARITY == PAR_ODD);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_width_chk
    $error("uart_core: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_core: STOP_BITS must be 1 or 2");
  end

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .tick_o(tick));

  // ---------------- transmitter ----------------
  tx_state_t             tx_state_q, tx_state_d;
  logic [3:0]            tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic                  tx_par_q, tx_par_d, tx_stop_q, tx_stop_d, tx_pend_q, tx_pend_d;
  logic                  tx_en_q, tx_hs, tx_bit_end;

  assign tx_hs      = tx_valid && tx_ready;
  assign tx_bit_end = tick && (tx_tick_q == LAST_TICK);

  // tx_en_q keeps tx_ready low during reset and raises it on the first clock after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_pend_q  <= tx_pend_d;
      tx_en_q    <= 1'b1;
    end
  end

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_pend_d  = tx_pend_q;
    if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 4'd1;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_hs) begin
          tx_shreg_d = tx_data;
          tx_par_d   = (^tx_data) ^ PAR_INV;
          tx_pend_d  = 1'b1;
        end
        // The frame starts on a tick boundary so the start bit lasts a full 16 ticks.
        if ((tx_hs || tx_pend_q) && tick) begin
          tx_state_d = TX_START;
          tx_pend_d  = 1'b0;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_stop_d  = 1'b0;
        end
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shreg_d = tx_shreg_q >> 1;
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == LAST_BIT) tx_state_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        tx_stop_d = 1'b1;
        if (tx_stop_q == LAST_STOP) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx        = 1'b1;
    tx_active = 1'b1;
    tx_done   = 1'b0;
    tx_ready  = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_active = 1'b0;
        tx_ready  = tx_en_q && !tx_pend_q;
      end
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shreg_q[0];
      TX_PARITY: tx = tx_par_q;
      TX_STOP:   tx_done = tx_bit_end && (tx_stop_q == LAST_STOP);
      default:   tx_active = 1'b0;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t             rx_state_q, rx_state_d;
  logic [1:0]            rx_sync_q;
  logic                  rx_s, rx_prev_q, rx_fall, rx_sample, rx_done, rx_hs;
  logic [3:0]            rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d, rx_data_q;
  logic                  rx_par_q, rx_par_d;
  logic                  rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  assign rx_s      = rx_sync_q[1];
  assign rx_fall   = rx_prev_q && !rx_s;
  assign rx_sample = tick && (rx_tick_q == ((rx_state_q == RX_START) ? MID_TICK : LAST_TICK));
  assign rx_hs     = rx_valid_q && rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
      rx_par_q   <= rx_par_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_par_d   = rx_par_q;
    if (rx_state_q != RX_IDLE && tick) rx_tick_d = rx_tick_q + 4'd1;
    unique case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
      end
      // A line that is high again at mid start bit was only a glitch.
      RX_START: if (rx_sample) begin
        rx_tick_d  = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_sample) begin
        rx_shreg_d = {rx_s, rx_shreg_q[DATA_WIDTH-1:1]};
        rx_bit_d   = rx_bit_q + 4'd1;
        if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (rx_sample) begin
        rx_par_d   = rx_s;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = 1'b0;
    if (rx_state_q == RX_STOP) rx_done = rx_sample;
  end

  // A word consumed in the same cycle as a new completion frees the slot for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (rx_done && (!rx_valid_q || rx_hs)) begin
      rx_data_q    <= rx_shreg_q;
      rx_valid_q   <= 1'b1;
      parity_err_q <= (PARITY != PAR_NONE) && (rx_par_q != ((^rx_shreg_q) ^ PAR_INV));
      frame_err_q  <= !rx_s;
    end else if (rx_done) begin
      overrun_q <= 1'b1;
    end else if (rx_hs) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
